mem_port_arbiter: RTL and testbench

Shares the single-port, synchronous-read instruction/data RAM between the fetch stage and the load/store path of the CPU. It arbitrates fetch versus data requests and sequences each access as a two-cycle transaction. It formats byte, half-word and word stores into lane enables, extracts and extends loads, and halts all memory traffic when the core executes ECALL. It sits between the PC/fetch logic, the load/store control outputs (MemRead, MemWrite, sign, length) and the RAM macro.

---
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU requesters, the RAM macro and mem_port_arbiter.
// The slave view is the arbiter; the master view is the surrounding CPU and RAM.
interface mem_port_arbiter_if #(
    parameter int AW = 14
);
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_ready;
    logic [31:0]   if_rdata;

    logic          d_req;
    logic          d_we;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic [1:0]    d_length;
    logic          d_sign;
    logic          d_ready;
    logic [31:0]   d_rdata;
    logic          d_err;

    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_length, d_sign, mem_rdata,
        output if_ready, if_rdata, d_ready, d_rdata, d_err, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_length, d_sign, mem_rdata,
        input  if_ready, if_rdata, d_ready, d_rdata, d_err, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read RAM port between instruction fetch and load/store,
// two cycles per access, with store lane formatting, load extension and ECALL halt.
module mem_port_arbiter #(
    parameter int AW   = 14,
    parameter int CNTW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                halt,
    output logic                halted,
    output logic [CNTW-1:0]     conflict_cnt,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, IF_RSP, D_RSP, HALT} state_t;

    state_t      state, state_next;
    logic [1:0]  off_q, len_q;
    logic        sign_q, we_q, err_q;
    logic        grant_d, misaligned;
    logic [3:0]  store_we;
    logic [31:0] store_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic        unused_bits;

    assign unused_bits = ^{bus.if_addr[31:AW+2], bus.if_addr[1:0], bus.d_addr[31:AW+2]};

    always_comb begin
        misaligned = ((bus.d_length == 2'b01) && bus.d_addr[0]) ||
                     (bus.d_length[1] && (bus.d_addr[1:0] != 2'b00));
    end

    always_comb begin
        store_we    = 4'b1111;
        store_wdata = bus.d_wdata;
        case (bus.d_length)
            2'b00: begin
                store_we    = 4'b0001 << bus.d_addr[1:0];
                store_wdata = {4{bus.d_wdata[7:0]}};
            end
            2'b01: begin
                store_we    = bus.d_addr[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{bus.d_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Response-side extraction works on the copies latched at grant, since the
    // requester is free to change its operands once ready has pulsed.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = bus.mem_rdata[7:0];
            2'd1:    ld_byte = bus.mem_rdata[15:8];
            2'd2:    ld_byte = bus.mem_rdata[23:16];
            default: ld_byte = bus.mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (len_q)
            2'b00:   load_data = {{24{sign_q & ld_byte[7]}}, ld_byte};
            2'b01:   load_data = {{16{sign_q & ld_half[15]}}, ld_half};
            default: load_data = bus.mem_rdata;
        endcase
    end

    // Outputs are forced low while rst_n is asserted so held requests cannot
    // reach the RAM during reset.
    always_comb begin
        state_next    = state;
        grant_d       = 1'b0;
        halted        = 1'b0;
        bus.if_ready  = 1'b0;
        bus.if_rdata  = '0;
        bus.d_ready   = 1'b0;
        bus.d_rdata   = '0;
        bus.d_err     = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (halt) begin
                        state_next = HALT;
                    end else if (bus.d_req) begin
                        grant_d      = 1'b1;
                        state_next   = D_RSP;
                        bus.mem_en   = !misaligned;
                        bus.mem_addr = bus.d_addr[AW+1:2];
                        if (bus.d_we && !misaligned) begin
                            bus.mem_we    = store_we;
                            bus.mem_wdata = store_wdata;
                        end
                    end else if (bus.if_req) begin
                        state_next   = IF_RSP;
                        bus.mem_en   = 1'b1;
                        bus.mem_addr = bus.if_addr[AW+1:2];
                    end
                end
                IF_RSP: begin
                    bus.if_ready = 1'b1;
                    bus.if_rdata = bus.mem_rdata;
                    state_next   = IDLE;
                end
                D_RSP: begin
                    bus.d_ready = 1'b1;
                    bus.d_err   = err_q;
                    bus.d_rdata = (we_q || err_q) ? 32'd0 : load_data;
                    state_next  = IDLE;
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            off_q        <= '0;
            len_q        <= '0;
            sign_q       <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            state <= state_next;
            if (grant_d) begin
                off_q  <= bus.d_addr[1:0];
                len_q  <= bus.d_length;
                sign_q <= bus.d_sign;
                we_q   <= bus.d_we;
                err_q  <= misaligned;
            end
            if ((state == IDLE) && !halt && bus.d_req && bus.if_req && (conflict_cnt != '1))
                conflict_cnt <= conflict_cnt + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural RAM plus a byte-array
// reference model that predicts every grant and response from the access rules.
module tb_mem_port_arbiter;
    localparam int AW   = 14;
    localparam int CNTW = 4;
    localparam int WIN  = 4096;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            halt = 1'b0;
    logic            halted;
    logic [CNTW-1:0] conflict_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    logic [31:0]   ram [0:(1<<AW)-1];
    logic [7:0]    ref_mem [0:WIN-1];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [31:0]   pre_data = '0;

    mem_port_arbiter_if #(.AW(AW)) bus ();

    mem_port_arbiter #(.AW(AW), .CNTW(CNTW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .halt         (halt),
        .halted       (halted),
        .conflict_cnt (conflict_cnt),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (bus.mem_en) begin
            bus.mem_rdata <= ram[bus.mem_addr];
            for (int l = 0; l < 4; l++)
                if (bus.mem_we[l]) ram[bus.mem_addr][8*l +: 8] <= bus.mem_wdata[8*l +: 8];
        end
    end

    function automatic int size_of(input logic [1:0] len);
        return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input int a, input logic [1:0] len, input logic sg);
        int n = size_of(len);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
        if (n < 4 && sg && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        return v;
    endfunction

    function automatic logic [3:0] ref_lanes(input int a, input logic [1:0] len);
        logic [3:0] m = '0;
        for (int i = 0; i < size_of(len); i++) m[(a % 4) + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input logic [1:0] len);
        logic [31:0] v;
        int n = size_of(len);
        for (int l = 0; l < 4; l++) v[8*l +: 8] = wd[8*(l % n) +: 8];
        return v;
    endfunction

    function automatic void ref_store(input int a, input logic [31:0] wd, input logic [1:0] len);
        for (int i = 0; i < size_of(len); i++) ref_mem[a+i] = wd[8*i +: 8];
    endfunction

    task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] len, input logic sg,
                           output logic g_en, output logic [3:0] g_we, output logic [AW-1:0] g_addr,
                           output logic [31:0] g_wdata, output logic r_rdy, output logic [31:0] r_data,
                           output logic r_err);
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
        bus.d_length = len; bus.d_sign = sg;
        #1;
        g_en = bus.mem_en; g_we = bus.mem_we; g_addr = bus.mem_addr; g_wdata = bus.mem_wdata;
        @(posedge clk); #1;
        r_rdy = bus.d_ready; r_data = bus.d_rdata; r_err = bus.d_err;
        @(negedge clk);
        bus.d_req = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] a, output logic g_en, output logic [AW-1:0] g_addr,
                            output logic r_rdy, output logic [31:0] r_data);
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = a;
        #1;
        g_en = bus.mem_en; g_addr = bus.mem_addr;
        @(posedge clk); #1;
        r_rdy = bus.if_ready; r_data = bus.if_rdata;
        @(negedge clk);
        bus.if_req = 1'b0;
    endtask

    // Requests are held high throughout reset to prove the grant path is gated.
    task automatic test_reset();
        logic [31:0] w;
        bus.if_req = 1'b1; bus.if_addr = 32'h10; bus.d_req = 1'b1; bus.d_we = 1'b1;
        bus.d_addr = 32'h20; bus.d_wdata = 32'hDEADBEEF; bus.d_length = 2'b10; bus.d_sign = 1'b0;
        for (int i = 0; i < WIN/4; i++) begin
            w = (i == 4) ? 32'h00500093 : $urandom;
            @(negedge clk);
            pre_we = 1'b1; pre_addr = AW'(i); pre_data = w;
            for (int b = 0; b < 4; b++) ref_mem[4*i+b] = w[8*b +: 8];
        end
        @(negedge clk);
        pre_we = 1'b0;
        #1;
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_en: got %b expected 0", bus.mem_en); end
        checks++; if (bus.mem_we !== 4'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %b expected 0000", bus.mem_we); end
        checks++; if (bus.mem_addr !== '0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
        checks++; if ({bus.if_ready, bus.d_ready, bus.d_err, halted} !== 4'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {bus.if_ready, bus.d_ready, bus.d_err, halted}); end
        checks++; if (conflict_cnt !== '0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", conflict_cnt); end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        logic g_en, r_rdy; logic [AW-1:0] g_addr; logic [31:0] r_data;
        do_fetch(32'h10, g_en, g_addr, r_rdy, r_data);
        checks++; if (g_en !== 1'b1) begin errors++; $display("[TB] FAIL fetch_mem_en: got %b expected 1", g_en); end
        checks++; if (g_addr !== AW'(4)) begin errors++; $display("[TB] FAIL fetch_mem_addr: got %h expected 4", g_addr); end
        checks++; if (r_rdy !== 1'b1) begin errors++; $display("[TB] FAIL fetch_ready: got %b expected 1", r_rdy); end
        checks++; if (r_data !== 32'h00500093) begin errors++; $display("[TB] FAIL fetch_rdata: got %h expected 00500093", r_data); end
        @(posedge clk); #1;
        checks++; if ({bus.if_ready, bus.mem_en} !== 2'b00) begin errors++; $display("[TB] FAIL fetch_idle_after: got %b expected 00", {bus.if_ready, bus.mem_en}); end
    endtask

    task automatic test_collision();
        logic [31:0] fa = 32'h34;
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20; bus.d_length = 2'b10; bus.d_sign = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = fa;
        #1;
        checks++; if ({bus.mem_en, bus.mem_addr, bus.mem_we} !== {1'b1, AW'(8), 4'b0}) begin errors++; $display("[TB] FAIL coll_data_grant: got en=%b addr=%h we=%b expected en=1 addr=8 we=0000", bus.mem_en, bus.mem_addr, bus.mem_we); end
        @(posedge clk); #1;
        checks++; if ({bus.d_ready, bus.if_ready} !== 2'b10) begin errors++; $display("[TB] FAIL coll_d_ready: got d/if=%b expected 10", {bus.d_ready, bus.if_ready}); end
        checks++; if (bus.d_rdata !== ref_load(32'h20, 2'b10, 1'b0)) begin errors++; $display("[TB] FAIL coll_d_rdata: got %h expected %h", bus.d_rdata, ref_load(32'h20, 2'b10, 1'b0)); end
        @(negedge clk);
        bus.d_req = 1'b0;
        @(posedge clk); #1;
        checks++; if ({bus.mem_en, bus.mem_addr} !== {1'b1, AW'(fa >> 2)}) begin errors++; $display("[TB] FAIL coll_fetch_grant: got en=%b addr=%h expected en=1 addr=%h", bus.mem_en, bus.mem_addr, AW'(fa >> 2)); end
        @(posedge clk); #1;
        checks++; if ({bus.if_ready, bus.if_rdata} !== {1'b1, ref_load(fa, 2'b10, 1'b0)}) begin errors++; $display("[TB] FAIL coll_if_ready: got rdy=%b data=%h expected rdy=1 data=%h", bus.if_ready, bus.if_rdata, ref_load(fa, 2'b10, 1'b0)); end
        exp_cnt++;
        checks++; if (conflict_cnt !== CNTW'(exp_cnt)) begin errors++; $display("[TB] FAIL coll_cnt: got %0d expected %0d", conflict_cnt, exp_cnt); end
        @(negedge clk);
        bus.if_req = 1'b0;
    endtask

    task automatic test_store_load();
        logic g_en, r_rdy, r_err; logic [3:0] g_we; logic [AW-1:0] g_addr; logic [31:0] g_wd, r_data;
        do_data(1'b1, 32'h103, 32'h80, 2'b00, 1'b0, g_en, g_we, g_addr, g_wd, r_rdy, r_data, r_err);
        ref_store(32'h103, 32'h80, 2'b00);
        checks++; if ({g_we, g_wd} !== {4'b1000, 32'h80808080}) begin errors++; $display("[TB] FAIL sb_format: got we=%b wd=%h expected we=1000 wd=80808080", g_we, g_wd); end
        checks++; if ({r_rdy, r_data} !== {1'b1, 32'h0}) begin errors++; $display("[TB] FAIL sb_resp: got rdy=%b data=%h expected rdy=1 data=0", r_rdy, r_data); end
        do_data(1'b0, 32'h103, 32'h0, 2'b00, 1'b1, g_en, g_we, g_addr, g_wd, r_rdy, r_data, r_err);
        checks++; if (r_data !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL lb: got %h expected FFFFFF80", r_data); end
        do_data(1'b0, 32'h103, 32'h0, 2'b00, 1'b0, g_en, g_we, g_addr, g_wd, r_rdy, r_data, r_err);
        checks++; if (r_data !== 32'h00000080) begin errors++; $display("[TB] FAIL lbu: got %h expected 00000080", r_data); end
        do_data(1'b1, 32'h102, 32'h8001, 2'b01, 1'b0, g_en, g_we, g_addr, g_wd, r_rdy, r_data, r_err);
        ref_store(32'h102, 32'h8001, 2'b01);
        checks++; if ({g_we, g_wd} !== {4'b1100, 32'h80018001}) begin errors++; $display("[TB] FAIL sh_format: got we=%b wd=%h expected we=1100 wd=80018001", g_we, g_wd); end
        do_data(1'b0, 32'h102, 32'h0, 2'b01, 1'b1, g_en, g_we, g_addr, g_wd, r_rdy, r_data, r_err);
        checks++; if (r_data !== 32'hFFFF8001) begin errors++; $display("[TB] FAIL lh: got %h expected FFFF8001", r_data); end
    endtask

    task automatic test_misaligned();
        logic g_en, r_rdy, r_err; logic [3:0] g_we; logic [AW-1:0] g_addr; logic [31:0] g_wd, r_data;
        do_data(1'b0, 32'h102, 32'h0, 2'b10, 1'b0, g_en, g_we, g_addr, g_wd, r_rdy, r_data, r_err);
        checks++; if (g_en !== 1'b0) begin errors++; $display("[TB] FAIL mis_lw_en: got %b expected 0", g_en); end
        checks++; if ({r_rdy, r_err, r_data} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("[TB] FAIL mis_lw_resp: got rdy=%b err=%b data=%h expected rdy=1 err=1 data=0", r_rdy, r_err, r_data); end
        do_data(1'b1, 32'h105, 32'hABCD, 2'b01, 1'b0, g_en, g_we, g_addr, g_wd, r_rdy, r_data, r_err);
        checks++; if ({g_en, g_we, r_err} !== {1'b0, 4'b0, 1'b1}) begin errors++; $display("[TB] FAIL mis_sh: got en=%b we=%b err=%b expected en=0 we=0000 err=1", g_en, g_we, r_err); end
        do_data(1'b0, 32'h104, 32'h0, 2'b10, 1'b0, g_en, g_we, g_addr, g_wd, r_rdy, r_data, r_err);
        checks++; if ({r_err, r_data} !== {1'b0, ref_load(32'h104, 2'b10, 1'b0)}) begin errors++; $display("[TB] FAIL mis_untouched: got err=%b data=%h expected err=0 data=%h", r_err, r_data, ref_load(32'h104, 2'b10, 1'b0)); end
    endtask

    // Each call grants in the cycle right after the previous ready pulse.
    task automatic test_back_to_back();
        logic g_en, r_rdy, r_err; logic [3:0] g_we; logic [AW-1:0] g_addr; logic [31:0] g_wd, r_data;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                do_fetch(32'(8*k), g_en, g_addr, r_rdy, r_data);
                checks++; if ({g_en, r_rdy, r_data} !== {2'b11, ref_load(8*k, 2'b10, 1'b0)}) begin errors++; $display("[TB] FAIL b2b_fetch%0d: got en=%b rdy=%b data=%h expected 1 1 %h", k, g_en, r_rdy, r_data, ref_load(8*k, 2'b10, 1'b0)); end
            end else begin
                do_data(1'b0, 32'(8*k), 32'h0, 2'b10, 1'b0, g_en, g_we, g_addr, g_wd, r_rdy, r_data, r_err);
                checks++; if ({g_en, r_rdy, r_data} !== {2'b11, ref_load(8*k, 2'b10, 1'b0)}) begin errors++; $display("[TB] FAIL b2b_load%0d: got en=%b rdy=%b data=%h expected 1 1 %h", k, g_en, r_rdy, r_data, ref_load(8*k, 2'b10, 1'b0)); end
            end
        end
    endtask

    task automatic test_random();
        logic g_en, r_rdy, r_err, sg, we, mis; logic [3:0] g_we; logic [AW-1:0] g_addr;
        logic [31:0] g_wd, r_data, a, wd, exp; logic [1:0] len; int op, n;
        for (int k = 0; k < 80; k++) begin
            op = $urandom_range(0, 2); a = $urandom_range(0, WIN-4);
            len = 2'($urandom_range(0, 3)); sg = 1'($urandom_range(0, 1)); wd = $urandom;
            n = size_of(len);
            if ($urandom_range(0, 3) != 0) a = a - (a % n);
            if (op == 0) begin
                do_fetch(a, g_en, g_addr, r_rdy, r_data);
                exp = ref_load(a - (a % 4), 2'b10, 1'b0);
                checks++; if ({g_en, g_addr, r_rdy, r_data} !== {1'b1, AW'(a >> 2), 1'b1, exp}) begin errors++; $display("[TB] FAIL rnd_fetch%0d: got en=%b addr=%h rdy=%b data=%h expected en=1 addr=%h rdy=1 data=%h", k, g_en, g_addr, r_rdy, r_data, AW'(a >> 2), exp); end
            end else begin
                we = (op == 2); mis = (a % n) != 0;
                do_data(we, a, wd, len, sg, g_en, g_we, g_addr, g_wd, r_rdy, r_data, r_err);
                exp = (we || mis) ? 32'h0 : ref_load(a, len, sg);
                checks++; if ({g_en, r_rdy, r_err, r_data} !== {!mis, 1'b1, mis, exp}) begin errors++; $display("[TB] FAIL rnd_data%0d: got en=%b rdy=%b err=%b data=%h expected en=%b rdy=1 err=%b data=%h", k, g_en, r_rdy, r_err, r_data, !mis, mis, exp); end
                checks++; if (g_we !== ((we && !mis) ? ref_lanes(a, len) : 4'b0)) begin errors++; $display("[TB] FAIL rnd_we%0d: got %b expected %b", k, g_we, (we && !mis) ? ref_lanes(a, len) : 4'b0); end
                if (we && !mis) begin
                    checks++; if ({g_addr, g_wd} !== {AW'(a >> 2), ref_wdata(wd, len)}) begin errors++; $display("[TB] FAIL rnd_store%0d: got addr=%h wd=%h expected addr=%h wd=%h", k, g_addr, g_wd, AW'(a >> 2), ref_wdata(wd, len)); end
                    ref_store(a, wd, len);
                end
            end
        end
    endtask

    task automatic test_halt();
        logic g_en, r_rdy; logic [AW-1:0] g_addr; logic [31:0] r_data;
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40; bus.d_length = 2'b10; bus.d_sign = 1'b0;
        @(posedge clk); #1;
        halt = 1'b1;
        checks++; if ({bus.d_ready, bus.d_rdata} !== {1'b1, ref_load(32'h40, 2'b10, 1'b0)}) begin errors++; $display("[TB] FAIL halt_inflight: got rdy=%b data=%h expected rdy=1 data=%h", bus.d_ready, bus.d_rdata, ref_load(32'h40, 2'b10, 1'b0)); end
        @(negedge clk);
        bus.d_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h10;
        @(posedge clk); #1;
        checks++; if ({halted, bus.mem_en} !== 2'b00) begin errors++; $display("[TB] FAIL halt_idle_nogrant: got halted/en=%b expected 00", {halted, bus.mem_en}); end
        @(posedge clk); #1;
        checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_entered: got %b expected 1", halted); end
        halt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if ({halted, bus.mem_en, bus.if_ready} !== 3'b100) begin errors++; $display("[TB] FAIL halt_absorb%0d: got %b expected 100", i, {halted, bus.mem_en, bus.if_ready}); end
        end
        rst_n = 1'b0; exp_cnt = 0;
        #1;
        checks++; if ({halted, bus.mem_en} !== 2'b00) begin errors++; $display("[TB] FAIL halt_reset: got %b expected 00", {halted, bus.mem_en}); end
        bus.if_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_fetch(32'h10, g_en, g_addr, r_rdy, r_data);
        checks++; if ({g_en, r_rdy, r_data} !== {2'b11, ref_load(32'h10, 2'b10, 1'b0)}) begin errors++; $display("[TB] FAIL halt_recover: got en=%b rdy=%b data=%h expected 1 1 %h", g_en, r_rdy, r_data, ref_load(32'h10, 2'b10, 1'b0)); end
    endtask

    task automatic test_async_reset();
        logic g_en, r_rdy; logic [AW-1:0] g_addr; logic [31:0] r_data;
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h18;
        #1;
        checks++; if (bus.mem_en !== 1'b1) begin errors++; $display("[TB] FAIL arst_grant: got %b expected 1", bus.mem_en); end
        #2;
        rst_n = 1'b0; exp_cnt = 0;
        #1;
        checks++; if ({bus.mem_en, bus.mem_addr, bus.if_ready} !== {1'b0, AW'(0), 1'b0}) begin errors++; $display("[TB] FAIL arst_immediate: got en=%b addr=%h rdy=%b expected 0 0 0", bus.mem_en, bus.mem_addr, bus.if_ready); end
        @(posedge clk); #1;
        checks++; if ({bus.if_ready, halted, conflict_cnt} !== '0) begin errors++; $display("[TB] FAIL arst_no_pulse: got rdy=%b halted=%b cnt=%0d expected 0 0 0", bus.if_ready, halted, conflict_cnt); end
        @(negedge clk);
        bus.if_req = 1'b0; rst_n = 1'b1;
        do_fetch(32'h18, g_en, g_addr, r_rdy, r_data);
        checks++; if ({g_en, r_rdy, r_data} !== {2'b11, ref_load(32'h18, 2'b10, 1'b0)}) begin errors++; $display("[TB] FAIL arst_recover: got en=%b rdy=%b data=%h expected 1 1 %h", g_en, r_rdy, r_data, ref_load(32'h18, 2'b10, 1'b0)); end
    endtask

    // Both requesters held continuously: fetch starves and every other cycle is a contested IDLE.
    task automatic test_conflict_sat();
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_length = 2'b10; bus.d_sign = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h4;
        repeat (10) @(posedge clk);
        #1;
        exp_cnt = exp_cnt + 5;
        checks++; if (conflict_cnt !== CNTW'(exp_cnt)) begin errors++; $display("[TB] FAIL cnt_partial: got %0d expected %0d", conflict_cnt, exp_cnt); end
        repeat (40) @(posedge clk);
        #1;
        exp_cnt = (exp_cnt + 20 > (1 << CNTW) - 1) ? (1 << CNTW) - 1 : exp_cnt + 20;
        checks++; if (conflict_cnt !== CNTW'(exp_cnt)) begin errors++; $display("[TB] FAIL cnt_saturate: got %0d expected %0d", conflict_cnt, exp_cnt); end
        @(negedge clk);
        bus.d_req = 1'b0; bus.if_req = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.d_length = '0; bus.d_sign = 1'b0;
        test_reset();
        test_fetch();
        test_collision();
        test_store_load();
        test_misaligned();
        test_back_to_back();
        test_random();
        test_halt();
        test_async_reset();
        test_conflict_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
